dram_line_ctrl: RTL and testbench

DRAM_LINE_CTRL -- requirements
Module: dram_line_ctrl

---
 rtl/dram_line_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dram_line_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_line_ctrl.sv
// Moves one 128-bit line between the on-chip data RAM and DRAM (writeback or fill).
// Optional fill watchdog is enabled with the DRAM_TIMEOUT_EN macro.
module dram_line_ctrl #(
  parameter int DWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic [DWIDTH-3:0] req_line,
  input  logic [27:0]       req_dadr,
  output logic              done,
  output logic              err,
  output logic [DWIDTH-3:0] ram_radr_all,
  input  logic [127:0]      ram_rdata_all,
  output logic              ram_ren_all,
  output logic [DWIDTH-3:0] ram_wadr_all,
  output logic [127:0]      ram_wdata_all,
  output logic              ram_wen_all,
  output logic              dram_cmd_valid,
  input  logic              dram_cmd_ready,
  output logic              dram_cmd_we,
  output logic [27:0]       dram_cmd_adr,
  output logic [127:0]      dram_wdata,
  input  logic              dram_rvalid,
  input  logic [127:0]      dram_rdata
);

  typedef enum logic [2:0] {
    IDLE, WB_RD, WB_CAP, WB_CMD, FL_CMD, FL_WAIT, FL_WR, DONE
  } state_t;

  state_t              state_reg;
  logic [DWIDTH-3:0]   line_reg;
  logic [27:0]         dadr_reg;
  logic [127:0]        line_buf_reg;

  logic                req_ready_reg;
  logic                done_reg;
  logic                ram_ren_reg;
  logic [DWIDTH-3:0]   ram_radr_reg;
  logic                ram_wen_reg;
  logic [DWIDTH-3:0]   ram_wadr_reg;
  logic                cmd_valid_reg;
  logic                cmd_we_reg;
  logic [27:0]         cmd_adr_reg;

`ifdef DRAM_TIMEOUT_EN
  logic                err_reg;
  logic [7:0]          wait_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      done_reg      <= 1'b0;
      ram_ren_reg   <= 1'b0;
      ram_radr_reg  <= '0;
      ram_wen_reg   <= 1'b0;
      ram_wadr_reg  <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_we_reg    <= 1'b0;
      cmd_adr_reg   <= '0;
`ifdef DRAM_TIMEOUT_EN
      err_reg       <= 1'b0;
      wait_cnt_reg  <= '0;
`endif
    end else begin
      // Strobes are single-cycle: default them low and raise only on the entering transition.
      done_reg     <= 1'b0;
      ram_ren_reg  <= 1'b0;
      ram_radr_reg <= '0;
      ram_wen_reg  <= 1'b0;
      ram_wadr_reg <= '0;
`ifdef DRAM_TIMEOUT_EN
      err_reg      <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            line_reg      <= req_line;
            dadr_reg      <= req_dadr;
            req_ready_reg <= 1'b0;
            if (req_wb) begin
              state_reg    <= WB_RD;
              ram_ren_reg  <= 1'b1;
              ram_radr_reg <= req_line;
            end else begin
              state_reg     <= FL_CMD;
              cmd_valid_reg <= 1'b1;
              cmd_we_reg    <= 1'b0;
              cmd_adr_reg   <= req_dadr;
            end
          end
        end
        WB_RD: state_reg <= WB_CAP;
        WB_CAP: begin
          line_buf_reg  <= ram_rdata_all;
          state_reg     <= WB_CMD;
          cmd_valid_reg <= 1'b1;
          cmd_we_reg    <= 1'b1;
          cmd_adr_reg   <= dadr_reg;
        end
        WB_CMD: begin
          if (dram_cmd_ready) begin
            cmd_valid_reg <= 1'b0;
            cmd_we_reg    <= 1'b0;
            cmd_adr_reg   <= '0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end
        end
        FL_CMD: begin
          if (dram_cmd_ready) begin
            cmd_valid_reg <= 1'b0;
            cmd_adr_reg   <= '0;
            state_reg     <= FL_WAIT;
`ifdef DRAM_TIMEOUT_EN
            wait_cnt_reg  <= '0;
`endif
          end
        end
        FL_WAIT: begin
          if (dram_rvalid) begin
            line_buf_reg <= dram_rdata;
            ram_wen_reg  <= 1'b1;
            ram_wadr_reg <= line_reg;
            state_reg    <= FL_WR;
          end
`ifdef DRAM_TIMEOUT_EN
          // Count 254 marks the 255th silent cycle in FL_WAIT.
          else if (wait_cnt_reg == 8'd254) begin
            err_reg       <= 1'b1;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
`endif
        end
        FL_WR: begin
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          req_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          req_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // The line buffer is never reset, so its data outputs are gated by their registered strobes.
  assign req_ready      = req_ready_reg;
  assign done           = done_reg;
  assign ram_ren_all    = ram_ren_reg;
  assign ram_radr_all   = ram_radr_reg;
  assign ram_wen_all    = ram_wen_reg;
  assign ram_wadr_all   = ram_wadr_reg;
  assign ram_wdata_all  = ram_wen_reg ? line_buf_reg : '0;
  assign dram_cmd_valid = cmd_valid_reg;
  assign dram_cmd_we    = cmd_we_reg;
  assign dram_cmd_adr   = cmd_adr_reg;
  assign dram_wdata     = cmd_we_reg ? line_buf_reg : '0;

`ifdef DRAM_TIMEOUT_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_line_ctrl.sv
// Bench for dram_line_ctrl: event-timeline model checked every cycle plus directed literal checks.
module tb_dram_line_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_wb;
  logic [8:0]   req_line;
  logic [27:0]  req_dadr;
  logic         done, err;
  logic [8:0]   ram_radr_all, ram_wadr_all;
  logic [127:0] ram_rdata_all, ram_wdata_all;
  logic         ram_ren_all, ram_wen_all;
  logic         dram_cmd_valid, dram_cmd_ready, dram_cmd_we;
  logic [27:0]  dram_cmd_adr;
  logic [127:0] dram_wdata, dram_rdata;
  logic         dram_rvalid;

  dram_line_ctrl #(.DWIDTH(11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
    .req_line(req_line), .req_dadr(req_dadr),
    .done(done), .err(err),
    .ram_radr_all(ram_radr_all), .ram_rdata_all(ram_rdata_all), .ram_ren_all(ram_ren_all),
    .ram_wadr_all(ram_wadr_all), .ram_wdata_all(ram_wdata_all), .ram_wen_all(ram_wen_all),
    .dram_cmd_valid(dram_cmd_valid), .dram_cmd_ready(dram_cmd_ready), .dram_cmd_we(dram_cmd_we),
    .dram_cmd_adr(dram_cmd_adr), .dram_wdata(dram_wdata),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata)
  );

  always #5 clk = ~clk;

`ifdef DRAM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [127:0] PAT05 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Data RAM: preset contents come from pat(), later writes override them.
  function automatic logic [127:0] pat(input logic [8:0] line);
    if (line == 9'h005) return PAT05;
    return {4{32'hC0DE0000 | 32'(line)}};
  endfunction

  logic [127:0] mem [0:511];
  bit           written [0:511];

  always @(posedge clk) begin
    if (ram_ren_all) ram_rdata_all <= written[ram_radr_all] ? mem[ram_radr_all] : pat(ram_radr_all);
    if (ram_wen_all) begin
      mem[ram_wadr_all]     <= ram_wdata_all;
      written[ram_wadr_all] <= 1'b1;
    end
  end

  // Observed-event log used by the directed checks.
  int ren_cnt = 0, wen_cnt = 0, done_cnt = 0, err_cnt = 0, cv_cnt = 0;
  int last_ren_cyc, last_wen_cyc, last_done_cyc, last_err_cyc;
  logic [8:0]   last_ren_adr, last_wen_adr;
  logic [127:0] last_wen_data, last_cmd_wdata;
  logic [27:0]  last_cmd_adr;
  logic         last_cmd_we;

  // Transaction model: kind 0 idle, 1 writeback, 2 fill; acc/hs/rv are cycle stamps of
  // accept, command handshake and read return (-1 = not yet).
  int           kind = 0, acc = 0, hs = -1, rv = -1, err_cyc = -1;
  logic [8:0]   m_line;
  logic [27:0]  m_dadr;
  logic [127:0] m_data;
  bit           after_rst = 1'b1;

  always @(negedge clk) begin
    bit e_ready, e_ren, e_wen, e_cv, e_done, e_err, waiting;
    e_ready = (kind == 0);
    e_ren = 0; e_wen = 0; e_cv = 0; e_done = 0;
    e_err = (cyc == err_cyc);
    if (kind == 1) begin
      e_ren  = (cyc == acc + 1);
      e_cv   = (cyc >= acc + 3) && (hs < 0 || cyc <= hs);
      e_done = (hs >= 0) && (cyc == hs + 1);
    end else if (kind == 2) begin
      e_cv   = (cyc >= acc + 1) && (hs < 0 || cyc <= hs);
      e_wen  = (rv >= 0) && (cyc == rv + 1);
      e_done = (rv >= 0) && (cyc == rv + 2);
    end
    if (cyc >= 1) begin
      chk("req_ready", req_ready, e_ready);
      chk("ram_ren", ram_ren_all, e_ren);
      chk("ram_wen", ram_wen_all, e_wen);
      chk("cmd_valid", dram_cmd_valid, e_cv);
      chk("done", done, e_done);
      chk("err", err, e_err);
      if (e_ren) chk("ram_radr", ram_radr_all, m_line);
      if (e_wen) begin
        chk("ram_wadr", ram_wadr_all, m_line);
        chk("ram_wdata", ram_wdata_all, m_data);
      end
      if (e_cv) begin
        chk("cmd_we", dram_cmd_we, kind == 1);
        chk("cmd_adr", dram_cmd_adr, m_dadr);
        if (kind == 1) chk("cmd_wdata", dram_wdata, m_data);
      end
      if (after_rst)
        chk("rst_outputs_zero",
            {ram_radr_all, ram_wadr_all, ram_wdata_all, dram_cmd_we, dram_cmd_adr, dram_wdata}, '0);
    end

    if (ram_ren_all === 1'b1) begin ren_cnt++; last_ren_cyc = cyc; last_ren_adr = ram_radr_all; end
    if (ram_wen_all === 1'b1) begin wen_cnt++; last_wen_cyc = cyc; last_wen_adr = ram_wadr_all; last_wen_data = ram_wdata_all; end
    if (dram_cmd_valid === 1'b1) cv_cnt++;
    if (dram_cmd_valid === 1'b1 && dram_cmd_ready) begin
      last_cmd_adr = dram_cmd_adr; last_cmd_we = dram_cmd_we; last_cmd_wdata = dram_wdata;
    end
    if (done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
    if (err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end

    // Advance the model with the inputs that the next rising edge will sample.
    after_rst = rst;
    if (rst) begin
      kind = 0;
      err_cyc = -1;
    end else if (kind == 0) begin
      if (req_valid) begin
        kind = req_wb ? 1 : 2;
        acc = cyc; hs = -1; rv = -1;
        m_line = req_line; m_dadr = req_dadr;
        m_data = req_wb ? pat(req_line) : '0;
      end
    end else begin
      waiting = (kind == 2) && (hs >= 0) && (cyc > hs) && (rv < 0);
      if (e_cv && dram_cmd_ready) hs = cyc;
      else if (waiting) begin
        if (dram_rvalid) begin
          rv = cyc; m_data = dram_rdata;
        end else if (TO_EN && cyc == hs + 255) begin
          kind = 0; err_cyc = cyc + 1;
        end
      end
      if (e_done) kind = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while ((done_cnt + err_cnt) == base && n < budget) begin
      step(1);
      n++;
    end
    if ((done_cnt + err_cnt) == base) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_bound at cycle %0d: no done/err within %0d cycles", cyc, budget);
    end
  endtask

  int t0, r0, w0, d0, c0, e0;

  initial begin
    rst = 1; req_valid = 0; req_wb = 0; req_line = '0; req_dadr = '0;
    dram_cmd_ready = 0; dram_rvalid = 0; dram_rdata = '0;
    step(2);
    rst = 0;
    step(2);

    // Writeback of line 5 with DRAM always ready.
    t0 = cyc; r0 = ren_cnt; d0 = done_cnt + err_cnt;
    req_valid = 1; req_wb = 1; req_line = 9'h005; req_dadr = 28'h0000123; dram_cmd_ready = 1;
    step(1); req_valid = 0;
    wait_done(d0, 20);
    chk("wb_ren_count", ren_cnt - r0, 1);
    chk("wb_ren_cycle", last_ren_cyc - t0, 1);
    chk("wb_ren_adr", last_ren_adr, 9'h005);
    chk("wb_cmd_adr", last_cmd_adr, 28'h0000123);
    chk("wb_cmd_we", last_cmd_we, 1'b1);
    chk("wb_cmd_wdata", last_cmd_wdata, PAT05);
    chk("wb_done_cycle", last_done_cyc - t0, 4);
    step(2);

    // Fill of line 0x1FF, data returned three cycles after accept.
    t0 = cyc; w0 = wen_cnt; d0 = done_cnt + err_cnt;
    req_valid = 1; req_wb = 0; req_line = 9'h1FF; req_dadr = 28'hABCDEF0;
    step(1); req_valid = 0;
    step(2); dram_rvalid = 1; dram_rdata = {4{32'hDEADBEEF}};
    step(1); dram_rvalid = 0; dram_rdata = '0;
    wait_done(d0, 20);
    chk("fl_wen_count", wen_cnt - w0, 1);
    chk("fl_wen_cycle", last_wen_cyc - t0, 4);
    chk("fl_wen_adr", last_wen_adr, 9'h1FF);
    chk("fl_wen_data", last_wen_data, {4{32'hDEADBEEF}});
    chk("fl_done_cycle", last_done_cyc - t0, 5);
    chk("fl_cmd_we", last_cmd_we, 1'b0);
    chk("fl_cmd_adr", last_cmd_adr, 28'hABCDEF0);
    step(1);
    chk("fl_ram_content", mem[9'h1FF], {4{32'hDEADBEEF}});
    step(1);

    // Writeback stalled by DRAM for 7 cycles; a second request arrives meanwhile.
    t0 = cyc; c0 = cv_cnt; r0 = ren_cnt; d0 = done_cnt + err_cnt;
    dram_cmd_ready = 0;
    req_valid = 1; req_wb = 1; req_line = 9'h007; req_dadr = 28'h7654321;
    step(1); req_valid = 0;
    step(4);
    req_valid = 1; req_wb = 0; req_line = 9'h003; req_dadr = 28'h0000001;
    @(negedge clk);
    chk("stall_req_ready", req_ready, 1'b0);
    step(1); req_valid = 0;
    step(4); dram_cmd_ready = 1;
    wait_done(d0, 20);
    step(10);
    chk("stall_cv_cycles", cv_cnt - c0, 8);
    chk("stall_ren_count", ren_cnt - r0, 1);
    chk("stall_done_count", done_cnt + err_cnt - d0, 1);
    chk("stall_done_cycle", last_done_cyc - t0, 11);
    chk("stall_cmd_wdata", last_cmd_wdata, {4{32'hC0DE0007}});
    chk("stall_cmd_adr", last_cmd_adr, 28'h7654321);

    // Reset while waiting for fill data; a late rvalid must be ignored.
    t0 = cyc; w0 = wen_cnt; d0 = done_cnt;
    req_valid = 1; req_wb = 0; req_line = 9'h020; req_dadr = 28'h0000055;
    step(1); req_valid = 0;
    step(2); rst = 1;
    step(1); rst = 0; dram_rvalid = 1; dram_rdata = '1;
    step(1); dram_rvalid = 0; dram_rdata = '0;
    step(5);
    chk("rst_no_wen", wen_cnt - w0, 0);
    chk("rst_no_done", done_cnt - d0, 0);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    step(1);

    // Fill: stray rvalid during FL_CMD, real data on the first FL_WAIT cycle.
    t0 = cyc; w0 = wen_cnt; d0 = done_cnt + err_cnt; dram_cmd_ready = 0;
    req_valid = 1; req_wb = 0; req_line = 9'h0AA; req_dadr = 28'h0000F00;
    step(1); req_valid = 0;
    step(1); dram_rvalid = 1; dram_rdata = {4{32'h11111111}};
    step(1); dram_rvalid = 0; dram_rdata = '0; dram_cmd_ready = 1;
    step(1); dram_rvalid = 1; dram_rdata = {4{32'h22222222}};
    step(1); dram_rvalid = 0; dram_rdata = '0;
    wait_done(d0, 20);
    chk("edge_wen_count", wen_cnt - w0, 1);
    chk("edge_wen_cycle", last_wen_cyc - t0, 5);
    chk("edge_wen_data", last_wen_data, {4{32'h22222222}});
    chk("edge_done_cycle", last_done_cyc - t0, 6);
    step(2);

    // Fill that never gets data.
    t0 = cyc; w0 = wen_cnt; d0 = done_cnt; e0 = err_cnt;
    req_valid = 1; req_wb = 0; req_line = 9'h011; req_dadr = 28'h0000777;
    step(1); req_valid = 0;
`ifdef DRAM_TIMEOUT_EN
    wait_done(d0 + e0, 400);
    chk("to_err_count", err_cnt - e0, 1);
    chk("to_err_cycle", last_err_cyc - t0, 257);
    chk("to_no_wen", wen_cnt - w0, 0);
    chk("to_no_done", done_cnt - d0, 0);
    @(negedge clk);
    chk("to_req_ready", req_ready, 1'b1);
`else
    step(999);
    @(negedge clk);
    chk("hang_req_ready", req_ready, 1'b0);
    chk("hang_no_err", err_cnt - e0, 0);
    chk("hang_no_wen", wen_cnt - w0, 0);
    chk("hang_no_done", done_cnt - d0, 0);
    step(1); rst = 1;
    step(1); rst = 0;
`endif
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
